// File: rtl/matmul_scheduler.sv
// Sequences all 1024 row/column pairs of two resident 32x32 matrices through a dot-product unit
// and writes each returned result to row*32+col of the result buffer.
module matmul_scheduler #(
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned MAX_OUT  = 4,
  parameter int unsigned RES_W    = 24
) (
  input  logic             inter_refclk,
  input  logic             rst_n,
  input  logic             load_complete,
  output logic [4:0]       requested_a_row,
  output logic [4:0]       requested_b_col,
  input  logic [255:0]     a_row_in,
  input  logic [255:0]     b_col_in,
  output logic             dot_valid,
  input  logic             dot_ready,
  output logic [255:0]     dot_a,
  output logic [255:0]     dot_b,
  input  logic             dot_result_valid,
  input  logic [RES_W-1:0] dot_result,
  output logic             res_we,
  output logic [9:0]       res_addr,
  output logic [RES_W-1:0] res_data,
  output logic             busy,
  output logic             done
);

  localparam int unsigned WaitW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int unsigned OutW  = $clog2(MAX_OUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(READ_LAT - 1);
  localparam logic [OutW-1:0]  OutMax   = OutW'(MAX_OUT);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StIssue, StDrain, StDone} state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [WaitW-1:0] wait_q;
  logic [OutW-1:0]  out_q;
  logic [9:0]       res_cnt_q;
  logic             wrapped_q;
  logic             res_acc;
  logic             hs;

  // Results arriving with nothing in flight belong to no issue and are dropped.
  assign res_acc = dot_result_valid && (out_q != '0);
  // A full pipeline only accepts when a result retires in the same cycle.
  assign hs      = dot_valid && dot_ready && ((out_q != OutMax) || res_acc);

  // Reset asserts asynchronously but releases only after two clock edges.
  always_ff @(posedge inter_refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  always_ff @(posedge inter_refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      requested_a_row <= '0;
      requested_b_col <= '0;
      wait_q          <= '0;
      out_q           <= '0;
      res_cnt_q       <= '0;
      wrapped_q       <= 1'b0;
      dot_valid       <= 1'b0;
      dot_a           <= '0;
      dot_b           <= '0;
      res_we          <= 1'b0;
      res_addr        <= '0;
      res_data        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else if (sync_q[1]) begin
      res_we <= res_acc;
      if (res_acc) begin
        res_addr  <= res_cnt_q;
        res_data  <= dot_result;
        res_cnt_q <= res_cnt_q + 10'd1;
        if (res_cnt_q == 10'd1023) begin
          wrapped_q <= 1'b1;
        end
      end
      if (hs && !res_acc) begin
        out_q <= out_q + OutW'(1);
      end else if (!hs && res_acc) begin
        out_q <= out_q - OutW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (load_complete) begin
            state_q         <= StReq;
            requested_a_row <= '0;
            requested_b_col <= '0;
            wrapped_q       <= 1'b0;
            busy            <= 1'b1;
          end
        end
        StReq: begin
          state_q <= StWait;
          wait_q  <= '0;
        end
        StWait: begin
          if (wait_q == WaitLast) begin
            dot_a     <= a_row_in;
            dot_b     <= b_col_in;
            dot_valid <= 1'b1;
            state_q   <= StIssue;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StIssue: begin
          if (hs) begin
            dot_valid       <= 1'b0;
            state_q         <= StReq;
            requested_b_col <= requested_b_col + 5'd1;
            if (requested_b_col == 5'd31) begin
              requested_a_row <= requested_a_row + 5'd1;
              if (requested_a_row == 5'd31) begin
                state_q <= StDrain;
              end
            end
          end
        end
        StDrain: begin
          if ((out_q == '0) && wrapped_q) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        StDone: begin
          if (!load_complete) begin
            state_q <= StIdle;
            done    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler: identity A times all-ones B through a modelled loader and
// dot-product unit, with stall, back-pressure, reset and restart scenarios.
module tb_matmul_scheduler;

  localparam logic [255:0] ONES = {32{8'h01}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_complete;
  logic [4:0]   requested_a_row;
  logic [4:0]   requested_b_col;
  logic [255:0] a_row_in;
  logic [255:0] b_col_in;
  logic         dot_valid;
  logic         dot_ready;
  logic [255:0] dot_a;
  logic [255:0] dot_b;
  logic         dot_result_valid;
  logic [23:0]  dot_result;
  logic         res_we;
  logic [9:0]   res_addr;
  logic [23:0]  res_data;
  logic         busy;
  logic         done;

  int tests_run = 0;
  int tests_failed = 0;

  int           wr_count, order_errs, data_errs, hits103, exp_addr;
  int           hs_count = 0;
  logic         first_seen;
  logic [9:0]   first_addr;
  logic         auto_mode = 1'b0;
  logic [4:0]   ra_d1 = '0, ra_d2 = '0, cb_d1 = '0, cb_d2 = '0;
  logic         prev_valid = 1'b0;
  logic [255:0] prev_a = '0, prev_b = '0;

  always #5 clk = ~clk;

  matmul_scheduler dut (
    .inter_refclk     (clk),
    .rst_n            (rst_n),
    .load_complete    (load_complete),
    .requested_a_row  (requested_a_row),
    .requested_b_col  (requested_b_col),
    .a_row_in         (a_row_in),
    .b_col_in         (b_col_in),
    .dot_valid        (dot_valid),
    .dot_ready        (dot_ready),
    .dot_a            (dot_a),
    .dot_b            (dot_b),
    .dot_result_valid (dot_result_valid),
    .dot_result       (dot_result),
    .res_we           (res_we),
    .res_addr         (res_addr),
    .res_data         (res_data),
    .busy             (busy),
    .done             (done)
  );

  function automatic logic [255:0] a_row(input logic [4:0] r);
    logic [255:0] v;
    int idx;
    v = '0;
    idx = 8 * int'(r);
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [23:0] dot_fn(input logic [255:0] a, input logic [255:0] b);
    logic [23:0] s;
    s = '0;
    for (int k = 0; k < 32; k++) s = s + 24'(a[8*k +: 8]) * 24'(b[8*k +: 8]);
    return s;
  endfunction

  task automatic clear_mon();
    wr_count = 0; order_errs = 0; data_errs = 0; hits103 = 0; exp_addr = 0;
    first_seen = 1'b0; first_addr = '0;
  endtask

  // Loader (data zeroed until two edges after an index change), dot unit, write monitor.
  initial begin
    a_row_in = '0; b_col_in = '0;
    forever begin
      @(negedge clk);
      ra_d2 = ra_d1; ra_d1 = requested_a_row;
      cb_d2 = cb_d1; cb_d1 = requested_b_col;
      a_row_in = (ra_d2 == requested_a_row) ? a_row(requested_a_row) : '0;
      b_col_in = (cb_d2 == requested_b_col) ? ONES : '0;
      if (res_we === 1'b1) begin
        if (!first_seen) begin first_seen = 1'b1; first_addr = res_addr; end
        if (int'(res_addr) != exp_addr) order_errs++;
        if (res_data !== 24'd1) data_errs++;
        if (res_addr == 10'd103) hits103++;
        exp_addr = (exp_addr + 1) % 1024;
        wr_count++;
      end
      if (prev_valid && !dot_valid && rst_n) begin
        hs_count++;
        if (auto_mode) begin dot_result_valid = 1'b1; dot_result = dot_fn(prev_a, prev_b); end
      end else if (auto_mode) begin
        dot_result_valid = 1'b0;
      end
      prev_valid = dot_valid; prev_a = dot_a; prev_b = dot_b;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      tick();
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic start_run();
    load_complete = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    clear_mon();
    load_complete = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_complete = 1'b0; dot_ready = 1'b0;
    dot_result_valid = 1'b0; dot_result = '0;
    clear_mon();
    for (int i = 0; i < 3; i++) tick();
    tests_run++; if ({dot_valid, res_we, busy, done} !== 4'b0) begin tests_failed++;
      $display("FAIL reset_flags: got %b, expected 0000", {dot_valid, res_we, busy, done}); end
    tests_run++; if ({requested_a_row, requested_b_col, res_addr} !== 20'd0) begin tests_failed++;
      $display("FAIL reset_idx_addr: got %0h, expected 0", {requested_a_row, requested_b_col, res_addr}); end
    tests_run++; if ((dot_a | dot_b) !== 256'd0 || res_data !== 24'd0) begin tests_failed++;
      $display("FAIL reset_data: got a=%0h b=%0h r=%0h, expected 0", dot_a, dot_b, res_data); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tests_run++; if ({busy, done} !== 2'b00) begin tests_failed++;
      $display("FAIL idle_no_load: got %b, expected 00", {busy, done}); end
  endtask

  task automatic test_spurious_idle();
    dot_result = 24'h000abc; dot_result_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    dot_result_valid = 1'b0;
    tick(); tick();
    tests_run++; if (wr_count != 0 || res_we !== 1'b0) begin tests_failed++;
      $display("FAIL spurious_write: got %0d writes, expected 0", wr_count); end
    tests_run++; if (res_addr !== 10'd0 || busy !== 1'b0) begin tests_failed++;
      $display("FAIL spurious_state: got addr=%0d busy=%b, expected 0 0", res_addr, busy); end
  endtask

  task automatic test_full_run();
    bit ok;
    int n;
    auto_mode = 1'b1; dot_ready = 1'b1;
    clear_mon();
    load_complete = 1'b1;
    n = 0;
    while (dot_valid !== 1'b1 && n < 20) begin tick(); n++; end
    tests_run++; if (n != 4) begin tests_failed++;
      $display("FAIL first_issue_latency: got %0d, expected 4", n); end
    tests_run++; if ({requested_a_row, requested_b_col} !== 10'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_issue_idx: got %0h busy=%b, expected 0 1",
               {requested_a_row, requested_b_col}, busy); end
    tests_run++; if (dot_a !== a_row(5'd0) || dot_b !== ONES) begin tests_failed++;
      $display("FAIL first_operands: got a=%0h b=%0h, expected a=%0h b=%0h",
               dot_a, dot_b, a_row(5'd0), ONES); end
    wait_done(ok);
    tests_run++; if (!ok) begin tests_failed++;
      $display("FAIL full_run_done: got timeout, expected done"); end
    tests_run++; if (wr_count != 1024 || order_errs != 0 || data_errs != 0) begin tests_failed++;
      $display("FAIL full_run_writes: got %0d writes %0d order %0d data errs, expected 1024 0 0",
               wr_count, order_errs, data_errs); end
    tests_run++; if ({busy, done} !== 2'b01) begin tests_failed++;
      $display("FAIL full_run_status: got %b, expected 01", {busy, done}); end
  endtask

  task automatic test_done_hold();
    bit ok;
    for (int i = 0; i < 20; i++) tick();
    tests_run++; if (done !== 1'b1 || busy !== 1'b0 || wr_count != 1024) begin tests_failed++;
      $display("FAIL done_hold: got done=%b busy=%b writes=%0d, expected 1 0 1024",
               done, busy, wr_count); end
    load_complete = 1'b0;
    tick(); tick();
    tests_run++; if (done !== 1'b0) begin tests_failed++;
      $display("FAIL done_release: got %b, expected 0", done); end
    clear_mon();
    load_complete = 1'b1;
    wait_done(ok);
    tests_run++; if (!ok || wr_count != 1024 || order_errs != 0 || data_errs != 0) begin
      tests_failed++;
      $display("FAIL second_run: got ok=%0d writes=%0d order=%0d data=%0d, expected 1 1024 0 0",
               ok, wr_count, order_errs, data_errs); end
  endtask

  task automatic test_stall();
    bit ok;
    bit found;
    int hs0;
    start_run();
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (dot_valid === 1'b1 && requested_a_row == 5'd3 && requested_b_col == 5'd7) begin
        found = 1'b1; break;
      end
    end
    dot_ready = 1'b0;
    hs0 = hs_count;
    tests_run++; if (!found) begin tests_failed++;
      $display("FAIL stall_reach: got timeout, expected issue (3,7)"); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (dot_valid !== 1'b1 || dot_a !== a_row(5'd3) || dot_b !== ONES ||
          {requested_a_row, requested_b_col} !== {5'd3, 5'd7}) begin
        tests_failed++;
        $display("FAIL stall_hold: got v=%b row=%0d col=%0d a=%0h, expected 1 3 7 %0h",
                 dot_valid, requested_a_row, requested_b_col, dot_a, a_row(5'd3));
      end
    end
    dot_ready = 1'b1;
    tick(); tick(); tick();
    tests_run++; if (hs_count - hs0 != 1) begin tests_failed++;
      $display("FAIL stall_handshakes: got %0d, expected 1", hs_count - hs0); end
    wait_done(ok);
    tests_run++; if (!ok || hits103 != 1 || wr_count != 1024 || order_errs != 0 || data_errs != 0)
    begin
      tests_failed++;
      $display("FAIL stall_writes: got ok=%0d addr103=%0d writes=%0d order=%0d data=%0d, expected 1 1 1024 0 0",
               ok, hits103, wr_count, order_errs, data_errs);
    end
  endtask

  task automatic test_max_out();
    int hs0;
    auto_mode = 1'b0; dot_result_valid = 1'b0; dot_ready = 1'b1;
    hs0 = hs_count;
    start_run();
    for (int i = 0; i < 100 && (hs_count - hs0) < 4; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    tests_run++; if (hs_count - hs0 != 4) begin tests_failed++;
      $display("FAIL maxout_count: got %0d, expected 4", hs_count - hs0); end
    tests_run++; if (dot_valid !== 1'b1 || requested_b_col !== 5'd4 || requested_a_row !== 5'd0)
    begin
      tests_failed++;
      $display("FAIL maxout_stall: got v=%b row=%0d col=%0d, expected 1 0 4",
               dot_valid, requested_a_row, requested_b_col);
    end
    dot_result = 24'h000055; dot_result_valid = 1'b1;
    tick();
    dot_result_valid = 1'b0;
    tests_run++; if (hs_count - hs0 != 5) begin tests_failed++;
      $display("FAIL maxout_release: got %0d, expected 5", hs_count - hs0); end
    tests_run++; if (res_we !== 1'b1 || res_addr !== 10'd0 || res_data !== 24'h55) begin
      tests_failed++;
      $display("FAIL maxout_write: got we=%b addr=%0d data=%0h, expected 1 0 55",
               res_we, res_addr, res_data); end
    for (int i = 0; i < 10; i++) tick();
    tests_run++; if (hs_count - hs0 != 5 || dot_valid !== 1'b1 || requested_b_col !== 5'd5) begin
      tests_failed++;
      $display("FAIL maxout_still_full: got hs=%0d v=%b col=%0d, expected 5 1 5",
               hs_count - hs0, dot_valid, requested_b_col); end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    bit found;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    auto_mode = 1'b1; dot_ready = 1'b1; load_complete = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (dot_valid === 1'b1 && requested_a_row == 5'd10 && requested_b_col == 5'd20) begin
        found = 1'b1; break;
      end
    end
    tests_run++; if (!found) begin tests_failed++;
      $display("FAIL midrun_reach: got timeout, expected issue (10,20)"); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({dot_valid, res_we, busy, done} !== 4'b0 ||
                     {requested_a_row, requested_b_col, res_addr} !== 20'd0) begin
      tests_failed++;
      $display("FAIL midrun_reset_ctrl: got %b %0h, expected 0000 0",
               {dot_valid, res_we, busy, done}, {requested_a_row, requested_b_col, res_addr}); end
    tests_run++; if ((dot_a | dot_b) !== 256'd0 || res_data !== 24'd0) begin tests_failed++;
      $display("FAIL midrun_reset_data: got a=%0h b=%0h r=%0h, expected 0", dot_a, dot_b, res_data);
    end
    clear_mon();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++;
      $display("FAIL release_sync: got busy=%b one edge after release, expected 0", busy); end
    wait_done(ok);
    tests_run++; if (!ok || wr_count != 1024 || first_addr !== 10'd0 || order_errs != 0 ||
                     data_errs != 0) begin
      tests_failed++;
      $display("FAIL midrun_rerun: got ok=%0d writes=%0d first=%0d order=%0d data=%0d, expected 1 1024 0 0 0",
               ok, wr_count, first_addr, order_errs, data_errs); end
  endtask

  initial begin
    test_reset();
    test_spurious_idle();
    test_full_run();
    test_done_hold();
    test_stall();
    test_max_out();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/matmul_scheduler.md
MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

Interface
REQ-001 Parameters SHALL be: READ_LAT, default 2, cycles from index change to valid row/column data; MAX_OUT, default 4, maximum dot products in flight; RES_W, default 24, result width.
REQ-002 inter_refclk  in  1  sole clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 load_complete  in  1  level from the matrix loader; both 32x32 8-bit matrices are resident.
REQ-005 requested_a_row  out  5  A row index to the loader.
REQ-006 requested_b_col  out  5  B column index to the loader.
REQ-007 a_row_in  in  256  A row data, 32 bytes.
REQ-008 b_col_in  in  256  B column data, 32 bytes.
REQ-009 dot_valid  out  1  operands are valid for the dot-product unit.
REQ-010 dot_ready  in  1  the dot-product unit accepts the operands.
REQ-011 dot_a  out  256  captured row operand.
REQ-012 dot_b  out  256  captured column operand.
REQ-013 dot_result_valid  in  1  the dot-product unit's result is present, returned in issue order.
REQ-014 dot_result  in  RES_W  dot-product result.
REQ-015 res_we  out  1  result-buffer write enable.
REQ-016 res_addr  out  10  result address, row*32+col.
REQ-017 res_data  out  RES_W  result value.
REQ-018 busy  out  1  high in every state except IDLE and DONE.
REQ-019 done  out  1  high while the FSM is in DONE.

Function
REQ-020 FSM states SHALL be: IDLE, REQ, WAIT, ISSUE, DRAIN, DONE.
REQ-021 IDLE->REQ when load_complete=1; row and column indices are set to 0.
REQ-022 REQ SHALL drive the current indices for one cycle, then go to WAIT with wait counter=0.
REQ-023 WAIT SHALL count READ_LAT cycles; in its last cycle it captures a_row_in/b_col_in into dot_a/dot_b and goes to ISSUE.
REQ-024 ISSUE SHALL hold dot_valid=1 with stable dot_a/dot_b until dot_valid&&dot_ready; no handshake completes while outstanding==MAX_OUT and dot_result_valid=0.
REQ-025 On a handshake the column SHALL increment; at column 31 it wraps to 0 and the row increments; the next state is REQ.
REQ-026 A handshake at row 31, column 31 SHALL go to DRAIN instead of REQ.
REQ-027 The outstanding counter SHALL go +1 on a handshake, -1 on dot_result_valid, and stay unchanged when both occur in the same cycle.
REQ-028 dot_result_valid with outstanding==0 SHALL be ignored: no write, no count change.
REQ-029 Each accepted result SHALL produce res_we=1 one cycle later, with res_data=dot_result and res_addr=result counter; the result counter then increments, wrapping 1023->0.
REQ-030 DRAIN->DONE when outstanding==0 and the result counter has wrapped, i.e. 1024 results are written.
REQ-031 DONE->IDLE only when load_complete=0, so a held level does not restart the sequence.
REQ-032 Requested indices SHALL hold their value in every state except REQ transitions; load_complete falling mid-run SHALL be ignored.
REQ-033 Throughput: one issue per 2+READ_LAT cycles minimum; reads are not overlapped.

Reset
REQ-034 rst_n=0 SHALL immediately force: state IDLE; all indices, counters, dot_a, dot_b, res_addr and res_data to 0; dot_valid, res_we, busy, done to 0.
REQ-035 Reset mid-run SHALL abandon in-flight results; after release the sequence restarts from row 0, column 0 on load_complete.
REQ-036 Reset release SHALL be taken synchronously to inter_refclk; the first state change is allowed no earlier than the second rising edge after release.

Verification
REQ-037 Identity A and all-ones B, dot_ready=1, results 1 cycle after issue -> 1024 writes, addr 0..1023 in order, data=1 everywhere, done=1, busy=0.
REQ-038 dot_ready low for 5 cycles on issue (3,7) -> dot_a/dot_b stable, indices stay 3/7, exactly one handshake, no duplicate write at addr 103.
REQ-039 Results withheld, MAX_OUT=4 -> exactly 4 handshakes, then dot_valid held high with no acceptance; a result in the same cycle as the stall releases the fifth handshake, outstanding stays 4.
REQ-040 Spurious dot_result_valid in IDLE -> res_we stays 0, counter stays 0.
REQ-041 rst_n low at issue (10,20) -> all outputs 0 immediately; rerun writes addr 0 first and 1024 writes total.
REQ-042 load_complete held high after DONE -> stays in DONE; deassert then reassert -> a second full run of 1024 writes.
